// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// The BOOTH_UNSIGNED_EN option is handled in booth_mult_n.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        B_ZERO,
        B_POS1,
        B_POS2,
        B_NEG1,
        B_NEG2
    } booth_op_e;

    function automatic int cnt_width(input int w);
        return $clog2(w / 2 + 2);
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} to a partial-product select.
// Purely combinational.
module booth_recode
    import booth_pkg::*;
(
    input  logic [2:0] win,
    output booth_op_e  op
);

    always_comb begin
        op = B_ZERO;
        case (win)
            3'b001,
            3'b010:  op = B_POS1;
            3'b011:  op = B_POS2;
            3'b100:  op = B_NEG2;
            3'b101,
            3'b110:  op = B_NEG1;
            default: op = B_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential radix-4 Booth multiplier with full 2*WIDTH-bit product.
// Define BOOTH_UNSIGNED_EN to honour ctrl_unsigned (one extra step).
module booth_mult_n
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_unsigned,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    localparam int AW   = WIDTH + 2;
    localparam int CW   = cnt_width(WIDTH);
    localparam int HALF = WIDTH / 2;
    localparam logic [CW-1:0] LAST_S = CW'(HALF - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, a_q, mq_q;
    logic            guard_q;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q, hi_q;
    logic            exc_q;

    booth_op_e       op;
    logic [2:0]      win;
    logic [AW-1:0]   addend, sum;
    logic            cin;
    logic [2*AW:0]   full, shf;
    logic [AW-1:0]   acc_n, mq_n;
    logic            guard_n;
    logic            last;
    logic            uns;
    logic [CW-1:0]   last_cnt;
    logic [WIDTH-1:0] lo_n, hi_n;
    logic            exc_n;

`ifdef BOOTH_UNSIGNED_EN
    logic uns_q;
    assign uns = uns_q;
`else
    logic unused_unsigned;
    assign unused_unsigned = ctrl_unsigned;
    assign uns = 1'b0;
`endif

    assign win = {mq_q[1:0], guard_q};

    booth_recode u_recode (
        .win (win),
        .op  (op)
    );

    // Subtraction is inversion of the selected multiple plus carry-in.
    always_comb begin
        addend = '0;
        cin    = 1'b0;
        case (op)
            B_POS1: addend = a_q;
            B_POS2: addend = {a_q[AW-2:0], 1'b0};
            B_NEG1: begin
                addend = ~a_q;
                cin    = 1'b1;
            end
            B_NEG2: begin
                addend = ~{a_q[AW-2:0], 1'b0};
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
    end

    assign sum     = acc_q + addend + {{(AW-1){1'b0}}, cin};
    assign full    = {sum, mq_q, guard_q};
    assign shf     = {{2{sum[AW-1]}}, full[2*AW:2]};
    assign acc_n   = shf[2*AW:AW+1];
    assign mq_n    = shf[AW:1];
    assign guard_n = shf[0];

    assign last_cnt = uns ? CW'(HALF) : LAST_S;
    assign last     = (cnt_q == last_cnt);

    // Signed runs stop two bits early, so the low word sits higher in mq.
    always_comb begin
        lo_n  = mq_n[WIDTH+1:2];
        hi_n  = acc_n[WIDTH-1:0];
        exc_n = (hi_n != {WIDTH{lo_n[WIDTH-1]}});
`ifdef BOOTH_UNSIGNED_EN
        if (uns) begin
            lo_n  = mq_n[WIDTH-1:0];
            hi_n  = {acc_n[WIDTH-3:0], mq_n[WIDTH+1:WIDTH]};
            exc_n = (hi_n != '0);
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_MULT)
            state_d = BUSY;
        else if (state_q == BUSY && last)
            state_d = DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            a_q      <= '0;
            mq_q     <= '0;
            guard_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            exc_q    <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
            uns_q    <= 1'b0;
`endif
        end else if (ctrl_MULT) begin
            acc_q   <= '0;
            guard_q <= 1'b0;
            cnt_q   <= '0;
`ifdef BOOTH_UNSIGNED_EN
            uns_q   <= ctrl_unsigned;
            if (ctrl_unsigned) begin
                a_q  <= {2'b00, data_operandA};
                mq_q <= {2'b00, data_operandB};
            end else begin
                a_q  <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                mq_q <= {{2{data_operandB[WIDTH-1]}}, data_operandB};
            end
`else
            a_q  <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            mq_q <= {{2{data_operandB[WIDTH-1]}}, data_operandB};
`endif
        end else if (state_q == BUSY) begin
            acc_q   <= acc_n;
            mq_q    <= mq_n;
            guard_q <= guard_n;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                result_q <= lo_n;
                hi_q     <= hi_n;
                exc_q    <= exc_n;
            end
        end
    end

    assign data_result    = result_q;
    assign data_result_hi = hi_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign data_busy      = (state_q == BUSY);

endmodule

// File: tb/tb_booth_mult_n.sv
// Self-checking bench for booth_mult_n (WIDTH=32 and WIDTH=8 instances).
// Expected products come from a behavioural multiply model via a scoreboard.
module tb_booth_mult_n;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        exc;
    } exp_t;

    logic        clock, reset;
    logic        ctrl_MULT, ctrl_unsigned;
    logic [31:0] op_a, op_b, res, res_hi;
    logic        exc, rdy, busy;

    logic        mult8, uns8;
    logic [7:0]  a8, b8, res8, hi8;
    logic        exc8, rdy8, busy8;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    booth_mult_n #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_unsigned  (ctrl_unsigned),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (res),
        .data_result_hi (res_hi),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .data_busy      (busy)
    );

    booth_mult_n #(.WIDTH(8)) dut8 (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (mult8),
        .ctrl_unsigned  (uns8),
        .data_operandA  (a8),
        .data_operandB  (b8),
        .data_result    (res8),
        .data_result_hi (hi8),
        .data_exception (exc8),
        .data_resultRDY (rdy8),
        .data_busy      (busy8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic u);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        if (u) begin
            up    = {32'd0, a} * {32'd0, b};
            e.lo  = up[31:0];
            e.hi  = up[63:32];
            e.exc = (up > 64'h0000_0000_FFFF_FFFF);
        end else begin
            sp    = longint'($signed(a)) * longint'($signed(b));
            e.lo  = sp[31:0];
            e.hi  = sp[63:32];
            e.exc = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end
        sb.delete();
        sb.push_back(e);
    endtask

    // Caller is 1 time unit after a rising edge; returns likewise.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic u);
        op_a          = a;
        op_b          = b;
        ctrl_unsigned = u;
        ctrl_MULT     = 1'b1;
        push_exp(a, b, u);
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int   n;
        exp_t e;
        n = 0;
        while (!rdy && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_n));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lo"}, 64'(res), 64'(e.lo));
            check({tag, "_hi"}, 64'(res_hi), 64'(e.hi));
            check({tag, "_exc"}, 64'(exc), 64'(e.exc));
        end
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_unsigned = 1'b0;
        op_a          = '0;
        op_b          = '0;
        mult8         = 1'b0;
        uns8          = 1'b0;
        a8            = '0;
        b8            = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out", {res, res_hi}, 64'd0);
        check("rst_flags", {61'd0, exc, rdy, busy}, 64'd0);
        reset = 1'b0;

        start(32'd7, 32'hFFFF_FFFD, 1'b0);
        check("start_busy", 64'(busy), 64'd1);
        wait_done("s7x-3", 16);
        check("s7x-3_const", {res_hi, res}, 64'hFFFF_FFFF_FFFF_FFEB);

        repeat (3) @(posedge clock);
        #1;
        check("hold_rdy", 64'(rdy), 64'd1);
        check("hold_lo", 64'(res), 64'hFFFF_FFEB);

        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("smin", 16);
        check("smin_const", {31'd0, exc, res_hi}, 64'h1_0000_0000);

        for (int i = 0; i < 4; i++) begin
            start($urandom, $urandom, 1'b0);
            wait_done($sformatf("rnd%0d", i), 16);
        end

`ifdef BOOTH_UNSIGNED_EN
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("umax", 17);
        check("umax_const", {res_hi, res}, 64'hFFFF_FFFE_0000_0001);
        start(32'h0001_0000, 32'h0000_FFFF, 1'b1);
        wait_done("ufit", 17);
`endif

        start(32'd5, 32'd6, 1'b0);
        repeat (7) @(posedge clock);
        #1;
        check("abort_rdy", 64'(rdy), 64'd0);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("restart", 16);
        check("restart_const", {31'd0, exc, res_hi, res}, 64'd1);

        start(32'd3, 32'd3, 1'b0);
        repeat (15) @(posedge clock);
        #1;
        op_a      = 32'hFFFF_FFF0;
        op_b      = 32'd100;
        ctrl_MULT = 1'b1;
        push_exp(op_a, op_b, 1'b0);
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        check("b2b_rdy", 64'(rdy), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b", 16);

        start(32'd123, 32'd456, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_out", {res, res_hi}, 64'd0);
        check("mid_rst_flags", {61'd0, exc, rdy, busy}, 64'd0);
        sb.delete();
        start(32'd0, 32'h7FFF_FFFF, 1'b0);
        wait_done("zero", 16);

        a8    = 8'h80;
        b8    = 8'h80;
        mult8 = 1'b1;
        @(posedge clock);
        #1;
        mult8 = 1'b0;
        begin
            int n;
            n = 0;
            while (!rdy8 && n < 50) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("w8_lat", 64'(n), 64'd4);
        end
        check("w8_lo", 64'(res8), 64'h00);
        check("w8_hi", 64'(hi8), 64'h40);
        check("w8_exc", 64'(exc8), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
